// File: rtl/graph_pkg.sv
// graph_pkg: shared plot geometry and buffer FSM encoding for the graph renderer path
package graph_pkg;
  localparam int PLOT_HEIGHT = 440;
  localparam int DEFAULT_NUM_BINS = 256;
  localparam int DATA_BITS = 9;
  localparam int ADDR_BITS = 8;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/spectrum_bin_buffer_if.sv
// spectrum_bin_buffer_if: valid/ready magnitude stream from the FFT stage into the bin buffer
interface spectrum_bin_buffer_if #(
  parameter int MAG_BITS = 16
);
  logic                in_valid;
  logic                in_ready;
  logic [MAG_BITS-1:0] in_mag;
  logic                in_first;
  logic                in_last;
  modport master (output in_valid, in_mag, in_first, in_last, input in_ready);
  modport slave (input in_valid, in_mag, in_first, in_last, output in_ready);
endinterface

// File: rtl/spectrum_bank_ram.sv
// spectrum_bank_ram: ping-pong bin storage, one write port and one registered read port, bank bit is the address MSB
module spectrum_bank_ram #(
  parameter int DATA_BITS = 9,
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk_pixel,
  input  logic                 we,
  input  logic [ADDR_BITS:0]   waddr,
  input  logic [DATA_BITS-1:0] wdata,
  input  logic [ADDR_BITS:0]   raddr,
  output logic [DATA_BITS-1:0] rdata
);
  logic [DATA_BITS-1:0] mem [2**(ADDR_BITS+1)];
  // contents carry no reset so the array maps onto block RAM
  always_ff @(posedge clk_pixel) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/spectrum_bin_buffer.sv
// spectrum_bin_buffer: scales incoming spectrum bins into a back bank and flips banks only during vertical blanking
module spectrum_bin_buffer
  import graph_pkg::*;
#(
  parameter int DATA_BITS   = graph_pkg::DATA_BITS,
  parameter int NUM_BINS    = DEFAULT_NUM_BINS,
  parameter int MAG_BITS    = 16,
  parameter int SCALE_SHIFT = 7,
  parameter int MAX_VALUE   = PLOT_HEIGHT
) (
  input  logic                     clk_pixel,
  input  logic                     rst_n,
  input  logic                     frame_start,
  input  logic [ADDR_BITS-1:0]     data_addr,
  output logic [DATA_BITS-1:0]     data_value,
  spectrum_bin_buffer_if.slave     bus,
  output logic                     swap_pulse,
  output logic                     seq_err
);
  localparam logic [ADDR_BITS-1:0] LAST = ADDR_BITS'(NUM_BINS - 1);
  state_t               state_q, state_d;
  logic [ADDR_BITS-1:0] wr_idx_q, wr_idx_d, waddr;
  logic                 disp_bank_q, disp_bank_d, shown_q, shown_d;
  logic                 swap_q, swap_d, seq_err_q, seq_err_d;
  logic                 in_ready_q, in_ready_d, rd_ok_q, rd_ok_d;
  logic                 acc, we, fin;
  logic [MAG_BITS-1:0]  mag_sh;
  logic [DATA_BITS-1:0] wval, ram_q;
  assign mag_sh = bus.in_mag >> SCALE_SHIFT;
  assign wval = (mag_sh > MAG_BITS'(MAX_VALUE)) ? DATA_BITS'(MAX_VALUE) : mag_sh[DATA_BITS-1:0];
  assign bus.in_ready = in_ready_q;
  assign swap_pulse = swap_q;
  assign seq_err = seq_err_q;
  assign data_value = rd_ok_q ? ram_q : '0;
  // state, bank select and status flops; reset drops any partial frame and blanks the display
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_idx_q    <= '0;
      disp_bank_q <= 1'b0;
      shown_q     <= 1'b0;
      swap_q      <= 1'b0;
      seq_err_q   <= 1'b0;
      in_ready_q  <= 1'b0;
      rd_ok_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_idx_q    <= wr_idx_d;
      disp_bank_q <= disp_bank_d;
      shown_q     <= shown_d;
      swap_q      <= swap_d;
      seq_err_q   <= seq_err_d;
      in_ready_q  <= in_ready_d;
      rd_ok_q     <= rd_ok_d;
    end
  end
  // frame sequencing: fill the back bank in order, flag framing faults, swap only at blanking
  always_comb begin
    acc         = bus.in_valid && in_ready_q;
    fin         = bus.in_last && wr_idx_q == LAST;
    state_d     = state_q;
    wr_idx_d    = wr_idx_q;
    disp_bank_d = disp_bank_q;
    shown_d     = shown_q;
    swap_d      = 1'b0;
    seq_err_d   = seq_err_q;
    we          = 1'b0;
    waddr       = wr_idx_q;
    case (state_q)
      IDLE: if (acc) begin
        if (bus.in_first) begin
          we       = 1'b1;
          waddr    = '0;
          wr_idx_d = ADDR_BITS'(1);
          state_d  = FILL;
        end else seq_err_d = 1'b1;
      end
      FILL: if (acc) begin
        we = 1'b1;
        if (bus.in_first) begin
          waddr     = '0;
          wr_idx_d  = ADDR_BITS'(1);
          seq_err_d = 1'b1;
        end else if (bus.in_last || wr_idx_q == LAST) begin
          wr_idx_d  = '0;
          state_d   = fin ? DONE : IDLE;
          seq_err_d = seq_err_q | ~fin;
        end else wr_idx_d = wr_idx_q + 1'b1;
      end
      DONE: if (frame_start) begin
        disp_bank_d = ~disp_bank_q;
        shown_d     = 1'b1;
        swap_d      = 1'b1;
        wr_idx_d    = '0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = state_d != DONE;
    rd_ok_d    = shown_q && ({1'b0, data_addr} < (ADDR_BITS + 1)'(NUM_BINS));
  end
  spectrum_bank_ram #(
    .DATA_BITS(DATA_BITS),
    .ADDR_BITS(ADDR_BITS)
  ) u_ram (
    .clk_pixel(clk_pixel),
    .we       (we),
    .waddr    ({~disp_bank_q, waddr}),
    .wdata    (wval),
    .raddr    ({disp_bank_q, data_addr}),
    .rdata    (ram_q)
  );
endmodule
